// File: rtl/irq_encoder8_3_pkg.sv
// Shared definitions for the 8-to-3 interrupt encoder: sizes, FSM states and
// a one-hot helper used to clear the served pending bit.
package irq_encoder8_3_pkg;

  localparam int N = 8;
  localparam int W = 3;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PRESENT = 1'b1
  } state_e;

  // Expand a 3-bit index to an 8-bit one-hot vector.
  function automatic logic [7:0] onehot8(input logic [2:0] sel);
    logic [7:0] vec;
    vec = 8'h00;
    vec[sel] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/irq_encoder8_3_prio_enc8_3.sv
// Combinational priority encoder: returns the index of the lowest set bit
// (bit 0 has highest priority) and whether any bit is set.
module prio_enc8_3 (
  input  logic [7:0] in_i,
  output logic [2:0] out_o,
  output logic       any_o
);

  // Lowest set bit wins; an all-zero input encodes to 0 with any_o low.
  always_comb begin
    out_o = 3'd0;
    any_o = |in_i;
    casez (in_i)
      8'b???????1: out_o = 3'd0;
      8'b??????10: out_o = 3'd1;
      8'b?????100: out_o = 3'd2;
      8'b????1000: out_o = 3'd3;
      8'b???10000: out_o = 3'd4;
      8'b??100000: out_o = 3'd5;
      8'b?1000000: out_o = 3'd6;
      8'b10000000: out_o = 3'd7;
      default:     out_o = 3'd0;
    endcase
  end

endmodule

// File: rtl/irq_encoder8_3.sv
// Interrupt request encoder: latches requests into a sticky pending register,
// presents the highest-priority unmasked one as a 3-bit index over a
// valid/ack handshake, and clears the served bit when the consumer acks.
module irq_encoder8_3
  import irq_encoder8_3_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic [7:0] mask,
  input  logic       ack,
  output logic [2:0] idx,
  output logic       valid,
  output logic [7:0] pending,
  output logic       overflow
);

  state_e     state_q;
  logic [2:0] idx_q;
  logic       valid_q;
  logic [7:0] pending_q;
  logic [7:0] pending_d;
  logic       overflow_q;
  logic       overflow_d;
  logic [7:0] clr_s;
  logic [7:0] cand_s;
  logic [2:0] enc_s;
  logic       any_s;

  // Masked candidates are selected from the registered pending bits only.
  assign cand_s = pending_q & ~mask;

  prio_enc8_3 u_prio (
    .in_i  (cand_s),
    .out_o (enc_s),
    .any_o (any_s)
  );

  // Clear mask for the bit being served: only an ack during presentation counts.
  always_comb begin
    clr_s = 8'h00;
    if ((state_q == ST_PRESENT) && ack) begin
      clr_s = onehot8(idx_q);
    end else begin
      clr_s = 8'h00;
    end
  end

  // Next pending (set wins over clear) and sticky overflow on a re-request
  // of a bit that is still pending and not being cleared this edge.
  always_comb begin
    pending_d  = (pending_q & ~clr_s) | req;
    overflow_d = overflow_q | (|(req & pending_q & ~clr_s));
  end

  // Pending and overflow registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q  <= 8'h00;
      overflow_q <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
    end
  end

  // Handshake FSM with registered idx/valid; a presented index is held
  // until acked, so later higher-priority requests never preempt it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= 3'd0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (any_s) begin
            idx_q   <= enc_s;
            valid_q <= 1'b1;
            state_q <= ST_PRESENT;
          end else begin
            valid_q <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        ST_PRESENT: begin
          if (ack) begin
            valid_q <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            valid_q <= 1'b1;
            state_q <= ST_PRESENT;
          end
        end
        default: begin
          valid_q <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign idx      = idx_q;
  assign valid    = valid_q;
  assign pending  = pending_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_irq_encoder8_3.sv
// Directed self-checking bench for irq_encoder8_3.
module tb_irq_encoder8_3;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] mask;
  logic       ack;
  logic [2:0] idx;
  logic       valid;
  logic [7:0] pending;
  logic       overflow;

  int n_checks = 0;
  int n_pass   = 0;

  irq_encoder8_3 dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .mask     (mask),
    .ack      (ack),
    .idx      (idx),
    .valid    (valid),
    .pending  (pending),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 8'hFF;
    mask  = 8'h00;
    ack   = 1'b0;

    // 1. Reset holds everything clear even with requests asserted.
    tick(2);
    chk("rst_pending",  32'(pending),  32'h00);
    chk("rst_valid",    32'(valid),    32'h0);
    chk("rst_overflow", 32'(overflow), 32'h0);
    chk("rst_idx",      32'(idx),      32'h0);
    rst_n = 1'b1;
    tick(1);
    req = 8'h00;
    chk("rel_pending", 32'(pending), 32'hFF);
    chk("rel_valid0",  32'(valid),   32'h0);
    tick(1);
    chk("rel_valid1",  32'(valid),   32'h1);
    chk("rel_idx",     32'(idx),     32'h0);
    // Async reset mid-cycle clears outputs with no clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_valid",   32'(valid),   32'h0);
    chk("async_pending", 32'(pending), 32'h00);
    tick(1);
    rst_n = 1'b1;

    // 2. Two requests served in priority order.
    req = 8'b0010_1000;
    tick(1);
    req = 8'h00;
    chk("t2_pend0", 32'(pending), 32'h28);
    chk("t2_val0",  32'(valid),   32'h0);
    tick(1);
    chk("t2_idx3",  32'(idx),     32'h3);
    chk("t2_val1",  32'(valid),   32'h1);
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    chk("t2_pend20", 32'(pending), 32'h20);
    chk("t2_val_ack", 32'(valid),  32'h0);
    tick(1);
    chk("t2_idx5",  32'(idx),     32'h5);
    chk("t2_val2",  32'(valid),   32'h1);
    ack = 1'b1;
    tick(1);
    chk("t2_pend_empty", 32'(pending), 32'h00);
    chk("t2_val_end",    32'(valid),   32'h0);
    // ack with nothing presented: no effect, idx keeps last value.
    tick(1);
    ack = 1'b0;
    chk("t2_stray_val",  32'(valid), 32'h0);
    chk("t2_stray_idx",  32'(idx),   32'h5);

    // 3. No preemption by a higher-priority arrival.
    req = 8'h10;
    tick(1);
    req = 8'h00;
    tick(1);
    chk("t3_idx4", 32'(idx), 32'h4);
    req = 8'h02;
    tick(1);
    req = 8'h00;
    chk("t3_pend12",  32'(pending), 32'h12);
    chk("t3_hold4a",  32'(idx),     32'h4);
    tick(1);
    chk("t3_hold4b",  32'(idx),     32'h4);
    chk("t3_holdval", 32'(valid),   32'h1);
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    chk("t3_pend02", 32'(pending), 32'h02);
    tick(1);
    chk("t3_idx1",   32'(idx),   32'h1);
    chk("t3_val1",   32'(valid), 32'h1);
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    chk("t3_pend_empty", 32'(pending), 32'h00);

    // 4. Masking: all masked holds pending without presenting.
    mask = 8'hFF;
    req  = 8'h81;
    tick(1);
    req = 8'h00;
    tick(2);
    chk("t4_mask_val",  32'(valid),   32'h0);
    chk("t4_mask_pend", 32'(pending), 32'h81);
    mask = 8'h01;
    tick(1);
    chk("t4_idx7", 32'(idx),   32'h7);
    chk("t4_val7", 32'(valid), 32'h1);
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    chk("t4_pend01", 32'(pending), 32'h01);
    mask = 8'h00;
    tick(1);
    chk("t4_idx0", 32'(idx), 32'h0);
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    chk("t4_pend_empty", 32'(pending), 32'h00);

    // 5. Set wins over clear on the same edge, without overflow.
    req = 8'h04;
    tick(1);
    req = 8'h00;
    tick(1);
    chk("t5_idx2", 32'(idx), 32'h2);
    ack = 1'b1;
    req = 8'h04;
    tick(1);
    ack = 1'b0;
    req = 8'h00;
    chk("t5_pend04", 32'(pending),  32'h04);
    chk("t5_ovf0",   32'(overflow), 32'h0);
    chk("t5_idle",   32'(valid),    32'h0);
    tick(1);
    chk("t5_re_idx", 32'(idx),   32'h2);
    chk("t5_re_val", 32'(valid), 32'h1);
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    chk("t5_pend_empty", 32'(pending), 32'h00);

    // 6. Overflow on a re-request of a pending, unpresented bit.
    req = 8'h41;
    tick(1);
    req = 8'h00;
    tick(1);
    chk("t6_idx0", 32'(idx),      32'h0);
    chk("t6_ovf0", 32'(overflow), 32'h0);
    req = 8'h40;
    tick(1);
    req = 8'h00;
    chk("t6_ovf1", 32'(overflow), 32'h1);
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    tick(1);
    chk("t6_idx6",    32'(idx),      32'h6);
    chk("t6_val6",    32'(valid),    32'h1);
    chk("t6_ovf_sty", 32'(overflow), 32'h1);
    // Async reset mid-handshake, then a late ack is ignored.
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_val",  32'(valid),    32'h0);
    chk("t6_async_ovf",  32'(overflow), 32'h0);
    chk("t6_async_pend", 32'(pending),  32'h00);
    chk("t6_async_idx",  32'(idx),      32'h0);
    tick(1);
    rst_n = 1'b1;
    ack   = 1'b1;
    tick(2);
    ack = 1'b0;
    chk("t6_late_val",  32'(valid),   32'h0);
    chk("t6_late_pend", 32'(pending), 32'h00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
